// File: rtl/ps2_keyboard_rx_if.sv
// Receive-side bus of the PS/2 keyboard receiver: byte, ready/error strobes
// and a busy flag. The receiver drives it (master); the Z80 bridge reads it (slave).
interface ps2_keyboard_rx_if;
  logic       PS2_RDY;
  logic [7:0] PS2_DAT;
  logic       PS2_ERR;
  logic       PS2_BUSY;

  modport master (output PS2_RDY, output PS2_DAT, output PS2_ERR, output PS2_BUSY);
  modport slave  (input  PS2_RDY, input  PS2_DAT, input  PS2_ERR, input  PS2_BUSY);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the keyboard clock,
// decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and
// publishes each good scan code with a one-cycle ready strobe. Bad parity,
// bad stop bit or a stalled frame produce a one-cycle error strobe instead.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic              GPU_CLK,
  input  logic              reset,
  input  logic              PS2_CLK_IN,
  input  logic              PS2_DATA_IN,
  ps2_keyboard_rx_if.master rx
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchroniser chains: index 1 is the stage safe to use in this clock domain.
  logic [1:0]     clk_sync_q, clk_sync_d;
  logic [1:0]     dat_sync_q, dat_sync_d;
  logic           filt_lvl_q, filt_lvl_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           filt_dly_q;
  logic           strobe_q, strobe_d;
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           rdy_q, rdy_d;
  logic [7:0]     dat_q, dat_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           bit_in;

  assign bit_in = dat_sync_q[1];

  // Front end: synchronisers, level filter on the clock and falling-edge strobe.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], PS2_CLK_IN};
    dat_sync_d = {dat_sync_q[0], PS2_DATA_IN};
    filt_lvl_d = filt_lvl_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_lvl_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_lvl_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    strobe_d = filt_dly_q & ~filt_lvl_q;
  end

  // Frame decoder, stall timeout and registered outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (strobe_q && !bit_in) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (strobe_q) begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (strobe_q) begin
          par_d   = bit_in;
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe_q) begin
          state_d = IDLE;
          if (bit_in && ((^shift_q) ^ par_q)) begin
            dat_d = shift_q;
            rdy_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A strobe always restarts the stall count, even if the count expires now.
    if (state_q != IDLE) begin
      if (strobe_q) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        state_d  = IDLE;
        err_d    = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // All state registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_lvl_q <= 1'b1;
      filt_cnt_q <= '0;
      filt_dly_q <= 1'b1;
      strobe_q   <= 1'b0;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      rdy_q      <= 1'b0;
      dat_q      <= 8'h00;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_lvl_q <= filt_lvl_d;
      filt_cnt_q <= filt_cnt_d;
      filt_dly_q <= filt_lvl_q;
      strobe_q   <= strobe_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      rdy_q      <= rdy_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign rx.PS2_RDY  = rdy_q;
  assign rx.PS2_DAT  = dat_q;
  assign rx.PS2_ERR  = err_q;
  assign rx.PS2_BUSY = busy_q;

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive GPU_CLK samples needed to accept a PS2_CLK_IN level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 250000 (2 ms at 125 MHz): maximum GPU_CLK cycles between falling edges inside a frame.
REQ-003 SHALL have port GPU_CLK  in  1  system clock, 125 MHz; the block's only clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port PS2_CLK_IN  in  1  raw keyboard clock pin, asynchronous to GPU_CLK.
REQ-006 SHALL have port PS2_DATA_IN  in  1  raw keyboard data pin, asynchronous to GPU_CLK.
REQ-007 SHALL have port PS2_RDY  out  1  HIGH for exactly one GPU_CLK cycle when a valid byte is on PS2_DAT; feeds the Z80 bridge PS2_RDY input.
REQ-008 SHALL have port PS2_DAT  out  8  last valid received scan-code byte, held until the next valid frame.
REQ-009 SHALL have port PS2_ERR  out  1  HIGH for exactly one cycle on a parity, stop-bit or timeout failure.
REQ-010 SHALL have port PS2_BUSY  out  1  HIGH while a frame is in progress (state not IDLE).

Function
REQ-011 SHALL pass PS2_CLK_IN and PS2_DATA_IN through separate 2-flop synchronisers before any other use.
REQ-012 SHALL hold a filtered clock level (reset value 1) that updates to the synchronised clock only after FILTER_LEN consecutive cycles of disagreement; any agreeing cycle clears the filter counter.
REQ-013 SHALL generate a one-cycle falling-edge strobe when the filtered clock goes 1->0; rising edges are ignored.
REQ-014 SHALL sample the synchronised data bit in the strobe cycle.
REQ-015 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-016 IDLE: strobe with data=0 SHALL go to DATA with bit counter=0; strobe with data=1 SHALL stay in IDLE with no output change.
REQ-017 DATA: each strobe SHALL shift the bit in LSB-first; the 3-bit counter SHALL increment, and the strobe for bit 7 SHALL go to PARITY.
REQ-018 PARITY: the strobe SHALL record the parity bit and go to STOP; odd parity SHALL be required (XOR of the 8 data bits and the parity bit = 1).
REQ-019 STOP: the strobe SHALL return to IDLE; if stop bit=1 and parity is good, PS2_DAT SHALL load the byte in the next cycle and PS2_RDY SHALL be HIGH for that same single cycle.
REQ-020 STOP: on a bad stop bit or bad parity, PS2_ERR SHALL pulse in the cycle after the strobe, PS2_RDY SHALL stay 0 and PS2_DAT SHALL stay unchanged.
REQ-021 In any non-IDLE state, a counter SHALL count cycles since the last strobe; on reaching TIMEOUT_CYCLES the FSM SHALL go to IDLE and PS2_ERR SHALL pulse once.
REQ-022 When a timeout and a strobe occur in the same cycle, the strobe SHALL win and the timeout counter SHALL clear.
REQ-023 The timeout counter SHALL be held at 0 in IDLE; its width SHALL be clog2(TIMEOUT_CYCLES+1) and it SHALL never wrap.
REQ-024 PS2_RDY and PS2_ERR SHALL never be HIGH in the same cycle.
REQ-025 PS2_BUSY SHALL go HIGH in the cycle after the start-bit strobe and LOW in the cycle after the stop strobe or after timeout.
REQ-026 Latency from a raw PS2_CLK_IN fall to its strobe SHALL be 2 + FILTER_LEN + 1 GPU_CLK cycles (fixed, deterministic).

Reset
REQ-027 reset LOW SHALL immediately, independent of GPU_CLK, force state=IDLE, PS2_RDY=0, PS2_DAT=8'h00, PS2_ERR=0 and PS2_BUSY=0.
REQ-028 reset LOW SHALL also clear the shift register, bit counter and timeout counter, set the synchronisers to 1, set the filter level to 1, and clear the filter counter.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame; the first strobe after release SHALL be handled in IDLE.

Verification
REQ-030 Frame start 0, data 0x1C LSB-first, parity 0, stop 1 -> PS2_DAT=0x1C, PS2_RDY one cycle, PS2_ERR never HIGH.
REQ-031 Frame data 0xF0 with wrong parity 0 -> PS2_ERR one cycle, PS2_RDY stays 0, PS2_DAT still 0x1C.
REQ-032 Frame data 0x5A, parity 1, stop bit 0 -> PS2_ERR one cycle, PS2_DAT unchanged, PS2_BUSY LOW afterward.
REQ-033 In IDLE, a 5-cycle low glitch on PS2_CLK_IN (FILTER_LEN=8) -> no strobe, PS2_BUSY stays 0; a 9-cycle low pulse with data 0 -> PS2_BUSY goes 1.
REQ-034 Start bit plus 3 data bits, then clock idle -> PS2_ERR pulse exactly TIMEOUT_CYCLES after the last strobe and PS2_BUSY 0; the following frame 0x29 (parity 0) -> PS2_DAT=0x29.
REQ-035 reset LOW after data bit 4 -> all outputs 0 at once; after release, frame 0x16 (parity 0) -> PS2_DAT=0x16 with a single PS2_RDY pulse.
